// File: rtl/axi4_write_ctrl.sv
// AXI4 INCR burst write master: streams a local SRAM byte range to an AXI slave with WSTRB edge masking.
// Optional macro WR_ERR_ABORT_EN: a BRESP[1] response ends the transfer instead of only flagging it.
module axi4_write_ctrl #(
    parameter int AXI_ID_WIDTH        = 1,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH      = 32,
    parameter int AXI_AWUSER_WIDTH    = 1,
    parameter int TRAN_BYTE_NUM_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]      w_target_slave_base_addr_i,
    input  logic [TRAN_BYTE_NUM_WIDTH-1:0] w_total_byte_num_i,
    input  logic                           w_start_i,
    output logic                           w_busy_o,
    output logic                           w_error_o,
    output logic [SRAM_ADDR_WIDTH-1:0]     w_sram_addr_o,
    output logic                           w_sram_rd_en_o,
    input  logic [AXI_DATA_WIDTH-1:0]      w_sram_data_i,
    output logic [AXI_ID_WIDTH-1:0]        M_AXI_AWID,
    output logic [AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [7:0]                     M_AXI_AWLEN,
    output logic [2:0]                     M_AXI_AWSIZE,
    output logic [1:0]                     M_AXI_AWBURST,
    output logic                           M_AXI_AWLOCK,
    output logic [3:0]                     M_AXI_AWCACHE,
    output logic [2:0]                     M_AXI_AWPROT,
    output logic [3:0]                     M_AXI_AWQOS,
    output logic [AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
    output logic                           M_AXI_AWVALID,
    input  logic                           M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
    output logic                           M_AXI_WLAST,
    output logic                           M_AXI_WVALID,
    input  logic                           M_AXI_WREADY,
    input  logic [AXI_ID_WIDTH-1:0]        M_AXI_BID,
    input  logic [1:0]                     M_AXI_BRESP,
    input  logic                           M_AXI_BVALID,
    output logic                           M_AXI_BREADY
);
    localparam int STRB      = AXI_DATA_WIDTH / 8;
    localparam int STRB_LOG2 = $clog2(STRB);
    localparam int CNT_W     = TRAN_BYTE_NUM_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] abase_q, burst_idx_q;
    logic [STRB_LOG2-1:0]      off_q, eoff_q;
    logic [CNT_W-1:0]          beat_remain_q;
    logic [7:0]                aw_len_q, wr_cnt_q;
    logic [8:0]                rd_left_q;
    logic                      first_q, err_q, rd_inflight_q;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;

    logic [AXI_DATA_WIDTH-1:0] fifo_mem [2];
    logic                      fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [1:0]                fifo_cnt_q;

    logic [STRB_LOG2-1:0] off_in, eoff_in;
    logic [CNT_W-1:0]     adj, beats_in;
    logic                 accept, aw_hs, w_hs, b_hs, burst_last, xfer_last, more_bursts, rd_en;
    logic [2:0]           occ;
    logic [STRB-1:0]      strb;
    logic                 unused_inputs;

    function automatic logic [8:0] burst_beats(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(256)) ? 9'd256 : n[8:0];
    endfunction

    assign off_in   = w_target_slave_base_addr_i[STRB_LOG2-1:0];
    assign adj      = CNT_W'(w_total_byte_num_i) + CNT_W'(off_in);
    assign eoff_in  = adj[STRB_LOG2-1:0];
    assign beats_in = (adj >> STRB_LOG2) + CNT_W'(eoff_in != '0);
    assign accept   = w_start_i && (state_q == S_IDLE) && (w_total_byte_num_i != '0);

    assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs       = M_AXI_BVALID && M_AXI_BREADY;
    assign burst_last = (wr_cnt_q == aw_len_q);
    // beat_remain_q already excludes the current burst once its AW has been accepted.
    assign xfer_last  = burst_last && (beat_remain_q == '0);
`ifdef WR_ERR_ABORT_EN
    assign more_bursts = (beat_remain_q != '0) && !M_AXI_BRESP[1];
`else
    assign more_bursts = (beat_remain_q != '0);
`endif

    // A beat popped this cycle frees its slot, which keeps one beat per cycle with a 2-entry FIFO.
    assign occ   = 3'(fifo_cnt_q) + 3'(rd_inflight_q) - 3'(w_hs);
    assign rd_en = ((state_q == S_AW) || (state_q == S_W)) && (rd_left_q != '0) && (occ < 3'd2);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_AW;
            S_AW:   if (aw_hs) state_d = S_W;
            S_W:    if (w_hs && burst_last) state_d = S_B;
            S_B:    if (b_hs) state_d = more_bursts ? S_AW : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        strb = '1;
        if (first_q) strb = strb & ({STRB{1'b1}} << off_q);
        if (xfer_last && (eoff_q != '0)) strb = strb & ((STRB'(1) << eoff_q) - STRB'(1));
        M_AXI_AWVALID = (state_q == S_AW);
        M_AXI_BREADY  = (state_q == S_B);
        M_AXI_WVALID  = (state_q == S_W) && (fifo_cnt_q != 2'd0);
        M_AXI_WDATA   = M_AXI_WVALID ? fifo_mem[fifo_rd_ptr_q] : '0;
        M_AXI_WSTRB   = M_AXI_WVALID ? strb : '0;
        M_AXI_WLAST   = M_AXI_WVALID && burst_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abase_q       <= '0;
            burst_idx_q   <= '0;
            off_q         <= '0;
            eoff_q        <= '0;
            beat_remain_q <= '0;
            aw_len_q      <= '0;
            wr_cnt_q      <= '0;
            rd_left_q     <= '0;
            first_q       <= 1'b0;
            err_q         <= 1'b0;
            sram_addr_q   <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= rd_en;
            if (accept) begin
                abase_q       <= w_target_slave_base_addr_i - AXI_ADDR_WIDTH'(off_in);
                off_q         <= off_in;
                eoff_q        <= eoff_in;
                beat_remain_q <= beats_in;
                burst_idx_q   <= '0;
                aw_len_q      <= 8'(burst_beats(beats_in) - 9'd1);
                rd_left_q     <= burst_beats(beats_in);
                sram_addr_q   <= '0;
                first_q       <= 1'b1;
                err_q         <= 1'b0;
            end
            if (aw_hs) begin
                beat_remain_q <= beat_remain_q - CNT_W'(aw_len_q) - CNT_W'(1);
                burst_idx_q   <= burst_idx_q + AXI_ADDR_WIDTH'(1);
                wr_cnt_q      <= '0;
            end
            if (rd_en) begin
                rd_left_q   <= rd_left_q - 9'd1;
                sram_addr_q <= sram_addr_q + SRAM_ADDR_WIDTH'(1);
            end
            if (w_hs) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
                first_q  <= 1'b0;
            end
            if (b_hs) begin
                if (M_AXI_BRESP[1]) err_q <= 1'b1;
                if (state_d == S_AW) begin
                    aw_len_q  <= 8'(burst_beats(beat_remain_q) - 9'd1);
                    rd_left_q <= burst_beats(beat_remain_q);
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count define validity and outputs are gated.
    always_ff @(posedge clk) begin
        if (rd_inflight_q) fifo_mem[fifo_wr_ptr_q] <= w_sram_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (rd_inflight_q) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
            if (w_hs)          fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            case ({rd_inflight_q, w_hs})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign w_busy_o       = (state_q != S_IDLE);
    assign w_error_o      = err_q;
    assign w_sram_addr_o  = sram_addr_q;
    assign w_sram_rd_en_o = rd_en;
    assign M_AXI_AWADDR   = abase_q + (burst_idx_q << (8 + STRB_LOG2));
    assign M_AXI_AWLEN    = aw_len_q;
    assign M_AXI_AWID     = '0;
    assign M_AXI_AWSIZE   = 3'(STRB_LOG2);
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = 4'b0010;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWQOS    = 4'b0000;
    assign M_AXI_AWUSER   = '0;

    assign unused_inputs = ^{M_AXI_BID, M_AXI_BRESP[0]};

endmodule

// File: tb/tb_axi4_write_ctrl.sv
// Directed bench for axi4_write_ctrl: slave/SRAM models, negedge monitor, hand-computed expectations.
module tb_axi4_write_ctrl;
`ifdef WR_ERR_ABORT_EN
    localparam int EXP_ERR_BURSTS = 1;
`else
    localparam int EXP_ERR_BURSTS = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] base;
    logic [15:0] total;
    logic        start;
    logic        busy, err, rd_en;
    logic [31:0] sram_addr, sram_data;
    logic [0:0]  awid, awuser, bid;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, bresp;
    logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  awcache, awqos, wstrb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int aw_n = 0;
    logic err_en = 1'b0;
    logic rand_mode = 1'b0;

    logic [31:0] mon_aw_addr[$], mon_w_data[$], mon_rd_addr[$];
    int          mon_aw_len[$], mon_aw_cyc[$], mon_w_cyc[$], mon_b_cyc[$];
    logic [3:0]  mon_w_strb[$];
    logic        mon_w_last[$];
    int          stable_errs = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_strb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bid    = 1'b0;
    assign bvalid = 1'b1;
    assign bresp  = (err_en && aw_n == 1) ? 2'b10 : 2'b00;

    axi4_write_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .w_target_slave_base_addr_i(base), .w_total_byte_num_i(total), .w_start_i(start),
        .w_busy_o(busy), .w_error_o(err), .w_sram_addr_o(sram_addr), .w_sram_rd_en_o(rd_en),
        .w_sram_data_i(sram_data),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return 32'h5A00_0000 + a * 32'h0001_0003;
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) if (rd_en) sram_data <= sram_word(sram_addr);

    initial begin
        awready = 1'b1;
        wready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            awready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            wready  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid && awready) begin
                mon_aw_addr.push_back(awaddr);
                mon_aw_len.push_back(int'(awlen));
                mon_aw_cyc.push_back(cyc);
                aw_n++;
            end
            if (wvalid && wready) begin
                mon_w_data.push_back(wdata);
                mon_w_strb.push_back(wstrb);
                mon_w_last.push_back(wlast);
                mon_w_cyc.push_back(cyc);
            end
            if (bvalid && bready) mon_b_cyc.push_back(cyc);
            if (rd_en) mon_rd_addr.push_back(sram_addr);
            if (prev_stall && (!wvalid || wdata !== prev_data || wstrb !== prev_strb)) stable_errs++;
            prev_stall = wvalid && !wready;
            prev_data  = wdata;
            prev_strb  = wstrb;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_aw_addr.delete(); mon_aw_len.delete(); mon_aw_cyc.delete();
        mon_w_data.delete(); mon_w_strb.delete(); mon_w_last.delete(); mon_w_cyc.delete();
        mon_b_cyc.delete(); mon_rd_addr.delete();
        stable_errs = 0;
        aw_n = 0;
    endtask

    // Returns #1 into the cycle after the accepting edge (cycle 1).
    task automatic start_xfer(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        base  = b;
        total = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string t, input int max_cyc, output int idle_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({t, "_done"}, 32'(busy), 0);
        idle_cyc = cyc;
    endtask

    task automatic check_beats(input string t, input int n, input logic [3:0] first_strb,
                               input logic [3:0] last_strb);
        int bad_data = 0;
        int bad_strb = 0;
        int bad_last = 0;
        int bad_rd = 0;
        logic [3:0] es;
        for (int i = 0; i < mon_w_data.size(); i++) begin
            es = (i == 0) ? first_strb : (i == n - 1) ? last_strb : 4'hF;
            if (mon_w_data[i] !== sram_word(32'(i))) bad_data++;
            if (mon_w_strb[i] !== es) bad_strb++;
            if (mon_w_last[i] !== ((i % 256 == 255) || (i == n - 1))) bad_last++;
        end
        for (int i = 0; i < mon_rd_addr.size(); i++)
            if (mon_rd_addr[i] !== 32'(i)) bad_rd++;
        check({t, "_w_n"}, 32'(mon_w_data.size()), 32'(n));
        check({t, "_wdata"}, 32'(bad_data), 0);
        check({t, "_wstrb"}, 32'(bad_strb), 0);
        check({t, "_wlast"}, 32'(bad_last), 0);
        check({t, "_rd_n"}, 32'(mon_rd_addr.size()), 32'(n));
        check({t, "_rd_addr"}, 32'(bad_rd), 0);
    endtask

    initial begin
        int idle_c;
        base  = '0;
        total = '0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_wstrb", 32'(wstrb), 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", 32'(awlen), 0);
        check("rst_awsize", 32'(awsize), 2);
        check("rst_awburst", 32'(awburst), 1);
        check("rst_awcache", 32'(awcache), 2);
        rst_n = 1'b1;

        // Aligned 16 bytes: one 4-beat burst, exact cycle timing.
        clear_mon();
        start_xfer(32'h1000, 16'd16);
        check("t1_busy_c1", 32'(busy), 1);
        check("t1_awvalid_c1", 32'(awvalid), 1);
        check("t1_awaddr", awaddr, 32'h1000);
        check("t1_awlen", 32'(awlen), 3);
        check("t1_rd_en_c1", 32'(rd_en), 1);
        check("t1_sram_addr_c1", sram_addr, 0);
        @(posedge clk);
        #1;
        check("t1_wvalid_c2", 32'(wvalid), 0);
        @(posedge clk);
        #1;
        check("t1_wvalid_c3", 32'(wvalid), 1);
        check("t1_wdata_c3", wdata, sram_word(0));
        wait_idle("t1", 100, idle_c);
        check("t1_aw_n", 32'(mon_aw_addr.size()), 1);
        check_beats("t1", 4, 4'hF, 4'hF);
        check("t1_b_n", 32'(mon_b_cyc.size()), 1);
        check("t1_busy_drop", 32'(idle_c), (mon_b_cyc.size() > 0) ? 32'(mon_b_cyc[0] + 1) : 32'hFFFF_FFFF);
        check("t1_tput", (mon_w_cyc.size() == 4) ? 32'(mon_w_cyc[3] - mon_w_cyc[0]) : 32'hFFFF_FFFF, 3);
        check("t1_bready_idle", 32'(bready), 0);
        check("t1_err", 32'(err), 0);

        // Unaligned 6 bytes from 0x1003, with a start pulse during the transfer that must be ignored.
        clear_mon();
        start_xfer(32'h1003, 16'd6);
        check("t2_awaddr", awaddr, 32'h1000);
        check("t2_awlen", 32'(awlen), 2);
        start_xfer(32'h5000, 16'd8);
        wait_idle("t2", 100, idle_c);
        check("t2_aw_n", 32'(mon_aw_addr.size()), 1);
        check_beats("t2", 3, 4'h8, 4'h1);

        // Zero-length start is ignored.
        start_xfer(32'h0040, 16'd0);
        check("t3_zero_busy", 32'(busy), 0);
        check("t3_zero_awvalid", 32'(awvalid), 0);

        // Asynchronous reset mid-transfer.
        clear_mon();
        start_xfer(32'h0, 16'd64);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_wvalid", 32'(wvalid), 0);
        check("rst_mid_awvalid", 32'(awvalid), 0);
        check("rst_mid_rd_en", 32'(rd_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single beat with both masks, straight after reset (FIFO must be empty).
        clear_mon();
        start_xfer(32'h2001, 16'd2);
        check("t4_awaddr", awaddr, 32'h2000);
        check("t4_awlen", 32'(awlen), 0);
        check("t4_sram_addr_c1", sram_addr, 0);
        wait_idle("t4", 100, idle_c);
        check_beats("t4", 1, 4'h6, 4'h6);

        // 1028 bytes: 256-beat burst then a 1-beat burst after the first B.
        clear_mon();
        start_xfer(32'h0, 16'd1028);
        wait_idle("t5", 1000, idle_c);
        check("t5_aw_n", 32'(mon_aw_addr.size()), 2);
        check("t5_awaddr1", (mon_aw_addr.size() >= 2) ? mon_aw_addr[1] : 32'hFFFF_FFFF, 32'h400);
        check("t5_awlen0", (mon_aw_len.size() >= 1) ? 32'(mon_aw_len[0]) : 32'hFFFF_FFFF, 255);
        check("t5_awlen1", (mon_aw_len.size() >= 2) ? 32'(mon_aw_len[1]) : 32'hFFFF_FFFF, 0);
        check("t5_aw2_after_b1", (mon_aw_cyc.size() >= 2 && mon_b_cyc.size() >= 1) ?
              32'(mon_aw_cyc[1] > mon_b_cyc[0]) : 0, 1);
        check("t5_tput", (mon_w_cyc.size() >= 256) ? 32'(mon_w_cyc[255] - mon_w_cyc[0]) : 32'hFFFF_FFFF, 255);
        check("t5_b_n", 32'(mon_b_cyc.size()), 2);
        check_beats("t5", 257, 4'hF, 4'hF);

        // Random AWREADY/WREADY stalls over 20 beats.
        clear_mon();
        rand_mode = 1'b1;
        start_xfer(32'h3000, 16'd80);
        wait_idle("t6", 2000, idle_c);
        rand_mode = 1'b0;
        check("t6_awlen", (mon_aw_len.size() >= 1) ? 32'(mon_aw_len[0]) : 32'hFFFF_FFFF, 19);
        check("t6_stable", 32'(stable_errs), 0);
        check_beats("t6", 20, 4'hF, 4'hF);

        // SLVERR on the first of two bursts.
        clear_mon();
        err_en = 1'b1;
        start_xfer(32'h0, 16'd1028);
        wait_idle("t7", 1000, idle_c);
        err_en = 1'b0;
        check("t7_err", 32'(err), 1);
        check("t7_aw_n", 32'(mon_aw_addr.size()), 32'(EXP_ERR_BURSTS));
        check("t7_b_n", 32'(mon_b_cyc.size()), 32'(EXP_ERR_BURSTS));
        check_beats("t7", (EXP_ERR_BURSTS == 1) ? 256 : 257, 4'hF, 4'hF);

        // Ignored start keeps the error; the next accepted start clears it.
        start_xfer(32'h0080, 16'd0);
        check("t8_err_kept", 32'(err), 1);
        clear_mon();
        start_xfer(32'h0010, 16'd4);
        check("t8_err_clr", 32'(err), 0);
        check("t8_awaddr", awaddr, 32'h10);
        wait_idle("t8", 100, idle_c);
        check_beats("t8", 1, 4'hF, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
